// File: rtl/rr_arbiter4_pkg.sv
// arb_pkg: shared sizes, state type and one-hot helper for the round-robin arbiter
package arb_pkg;
  localparam int NREQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NREQ'(1) << i;
  endfunction
endpackage

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between requesters and the arbiter
interface rr_arbiter4_if;
  import arb_pkg::*;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic busy;
  logic preempt;
  modport master(output req, input gnt, sel, busy, preempt);
  modport slave(input req, output gnt, sel, busy, preempt);
endinterface

// File: rtl/rr_arbiter4_pick4.sv
// rr_pick4: rotate requests by ptr, fixed-priority pick, unrotate to the winner index
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             any_o,
  output logic [SEL_W-1:0] win_o
);
  logic [NREQ-1:0] rot;
  logic [SEL_W-1:0] off;
  for (genvar i = 0; i < NREQ; i++) begin : g_rot
    assign rot[i] = req_i[ptr_i + SEL_W'(i)];
  end
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign win_o = ptr_i + off;
  assign any_o = |req_i;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with hold timeout and one dead cycle per handover
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic         clk,
  input logic         reset,
  rr_arbiter4_if.slave bus
);
  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  arb_state_t state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, win;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, preempt_q, preempt_d, any, tmo;
  rr_pick4 u_pick (
    .req_i(bus.req),
    .ptr_i(ptr_q),
    .any_o(any),
    .win_o(win)
  );
  assign tmo = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    gnt_d = '0;
    sel_d = sel_q;
    busy_d = 1'b0;
    preempt_d = 1'b0;
    case (state_q)
      GRANT:
        if (!bus.req[sel_q]) state_d = GAP;
        else if (tmo) begin
          state_d = GAP;
          preempt_d = 1'b1;
        end else begin
          gnt_d = gnt_q;
          busy_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      default:
        if (any) begin
          state_d = GRANT;
          gnt_d = onehot(win);
          sel_d = win;
          busy_d = 1'b1;
          cnt_d = '0;
          ptr_d = win + 1'b1;
        end else state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      sel_q <= '0;
      busy_q <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      busy_q <= busy_d;
      preempt_q <= preempt_d;
    end
  assign bus.gnt = gnt_q;
  assign bus.sel = sel_q;
  assign bus.busy = busy_q;
  assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed stimulus checked against an ownership-level model every cycle
module tb_rr_arbiter4;
  localparam int MH = 4;
  logic clk, reset;
  int n_chk = 0, n_fail = 0;
  int m_owner = -1, m_ptr = 0, m_hold = 0;
  logic [1:0] e_sel = '0;
  logic e_pre = 1'b0;
  rr_arbiter4_if bus ();
  rr_arbiter4 #(.MAX_HOLD(MH)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    int w;
    if (!reset) begin
      m_owner = -1;
      m_ptr = 0;
      m_hold = 0;
      e_sel = '0;
      e_pre = 1'b0;
      return;
    end
    e_pre = 1'b0;
    if (m_owner >= 0) begin
      if (!bus.req[m_owner]) m_owner = -1;
      else if (MH != 0 && m_hold == MH) begin
        m_owner = -1;
        e_pre = 1'b1;
      end else m_hold++;
    end else begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && bus.req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w >= 0) begin
        m_owner = w;
        m_hold = 1;
        e_sel = 2'(w);
        m_ptr = (w + 1) % 4;
      end
    end
  endtask
  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end
  always @(negedge clk)
    if (reset) begin
      chk("gnt", bus.gnt, m_owner >= 0 ? 32'(1) << m_owner : 0);
      chk("sel", bus.sel, e_sel);
      chk("busy", bus.busy, m_owner >= 0);
      chk("preempt", bus.preempt, e_pre);
      chk("onehot0", $onehot0(bus.gnt), 1);
      if (bus.busy) chk("gnt_sel", bus.gnt, 4'b0001 << bus.sel);
    end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  initial begin
    int ord[5] = '{0, 1, 2, 3, 0};
    reset = 1'b0;
    bus.req = 4'b0000;
    #12;
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_sel", bus.sel, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pre", bus.preempt, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus.req = 4'b1010;
    step(1);
    chk("t1_gnt", bus.gnt, 4'b0010);
    chk("t1_sel", bus.sel, 2'b01);
    chk("t1_busy", bus.busy, 1'b1);
    bus.req = 4'b1000;
    step(1);
    chk("t1_gap", bus.gnt, 4'b0000);
    step(1);
    chk("t1_gnt3", bus.gnt, 4'b1000);
    chk("t1_sel3", bus.sel, 2'b11);
    bus.req = 4'b0000;
    step(2);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rr_gnt", bus.gnt, 4'b0001 << ord[i]);
      step(2);
      chk("rr_busy", bus.busy, 1'b1);
      bus.req[ord[i]] = 1'b0;
      step(1);
      chk("rr_gap", bus.gnt, 4'b0000);
      bus.req[ord[i]] = 1'b1;
    end
    bus.req = 4'b0000;
    step(2);
    bus.req = 4'b0100;
    step(1);
    chk("t3_gnt", bus.gnt, 4'b0100);
    step(3);
    chk("t3_busy4", bus.busy, 1'b1);
    step(1);
    chk("t3_pre", bus.preempt, 1'b1);
    chk("t3_gap", bus.gnt, 4'b0000);
    step(1);
    chk("t3_regnt", bus.gnt, 4'b0100);
    chk("t3_pre0", bus.preempt, 1'b0);
    bus.req = 4'b0000;
    step(2);
    bus.req = 4'b0101;
    step(1);
    chk("t4_gnt0", bus.gnt, 4'b0001);
    step(4);
    chk("t4_pre", bus.preempt, 1'b1);
    step(1);
    chk("t4_gnt2", bus.gnt, 4'b0100);
    chk("t4_sel2", bus.sel, 2'b10);
    bus.req = 4'b0000;
    step(2);
    bus.req = 4'b0010;
    step(1);
    chk("t5_gnt", bus.gnt, 4'b0010);
    #1 reset = 1'b0;
    #1;
    chk("t5_rgnt", bus.gnt, 4'b0000);
    chk("t5_rbusy", bus.busy, 1'b0);
    chk("t5_rsel", bus.sel, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    bus.req = 4'b0011;
    step(1);
    chk("t5_gnt0", bus.gnt, 4'b0001);
    step(3);
    bus.req = 4'b0010;
    step(1);
    chk("t6_pre", bus.preempt, 1'b0);
    chk("t6_gap", bus.gnt, 4'b0000);
    step(1);
    chk("t6_gnt1", bus.gnt, 4'b0010);
    bus.req = 4'b0000;
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
